// File: rtl/xunit_sha256_round.sv
// xunit_sha256_round: SHA-256 compression unit that loads the chaining state, runs the rounds from a W_t/K_t stream
// and then streams out the feed-forward digest, with run/done control and a configurable start delay.
module xunit_sha256_round #(
    parameter int DATA_W  = 32,
    parameter int ROUNDS  = 64,
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DATA_W-1:0]  in1,
    output logic [DATA_W-1:0]  out0,
    output logic               out_valid,
    input  logic [DELAY_W-1:0] configDelay
);
    localparam int CW = DELAY_W > 7 ? DELAY_W : 7;
    typedef enum logic [2:0] {IDLE, WAIT, LOAD, ROUND, OUTPUT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] h [8];
    logic [DATA_W-1:0] w [8];
    logic [DATA_W-1:0] s0, s1, ch, maj, t1, t2;
    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction
    assign s0  = rotr(w[0], 2) ^ rotr(w[0], 13) ^ rotr(w[0], 22);
    assign s1  = rotr(w[4], 6) ^ rotr(w[4], 11) ^ rotr(w[4], 25);
    assign ch  = (w[4] & w[5]) ^ (~w[4] & w[6]);
    assign maj = (w[0] & w[1]) ^ (w[0] & w[2]) ^ (w[1] & w[2]);
    assign t1  = w[7] + s1 + ch + in1 + in0;
    assign t2  = s0 + maj;
    assign done      = state == IDLE;
    assign out_valid = state == OUTPUT;
    assign out0      = out_valid ? h[cnt[2:0]] + w[cnt[2:0]] : '0;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (run) begin
            state_n = WAIT;
            cnt_n   = CW'(configDelay);
        end else begin
            case (state)
                WAIT: begin
                    state_n = cnt == '0 ? LOAD : WAIT;
                    cnt_n   = cnt == '0 ? '0 : cnt - 1'b1;
                end
                LOAD: begin
                    state_n = cnt == CW'(7) ? ROUND : LOAD;
                    cnt_n   = cnt == CW'(7) ? '0 : cnt + 1'b1;
                end
                ROUND: begin
                    state_n = cnt == CW'(ROUNDS - 1) ? OUTPUT : ROUND;
                    cnt_n   = cnt == CW'(ROUNDS - 1) ? '0 : cnt + 1'b1;
                end
                OUTPUT: begin
                    state_n = cnt == CW'(7) ? IDLE : OUTPUT;
                    cnt_n   = cnt == CW'(7) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // Working registers: index 0 is a, 7 is h; each round shifts the word chain by one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                h[i] <= '0;
                w[i] <= '0;
            end
        end else if (state == LOAD) begin
            h[cnt[2:0]] <= in0;
            w[cnt[2:0]] <= in0;
        end else if (state == ROUND) begin
            w[0] <= t1 + t2;
            w[1] <= w[0];
            w[2] <= w[1];
            w[3] <= w[2];
            w[4] <= w[3] + t1;
            w[5] <= w[4];
            w[6] <= w[5];
            w[7] <= w[6];
        end
    end
endmodule

// File: tb/tb_xunit_sha256_round.sv
// tb_xunit_sha256_round: directed bench for the SHA-256 compression unit using the "abc" block,
// covering reset, start delay, mid-round restart, mid-output reset and back-to-back blocks.
module tb_xunit_sha256_round;
    logic        clk = 0;
    logic        rst = 0;
    logic        run = 0;
    logic        done;
    logic [31:0] in0 = 0;
    logic [31:0] in1 = 0;
    logic [31:0] out0;
    logic        out_valid;
    logic [7:0]  configDelay = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    logic [31:0] h_init [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] digest [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    logic [31:0] w_tab [64];
    xunit_sha256_round dut (
        .clk(clk), .rst(rst), .run(run), .done(done), .in0(in0), .in1(in1),
        .out0(out0), .out_valid(out_valid), .configDelay(configDelay)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // One "abc" block. started: run was already issued with configDelay=d and this is the first WAIT cycle.
    // chain: issue run (configDelay=cd) alongside the last output word. rw>=0: pull rst low at that output word.
    task automatic do_block(input int d, input bit started, input bit chain, input int cd, input int rw, input bit r0);
        int lows;
        int stray;
        lows = 0;
        stray = 0;
        if (!started) begin
            run = 1;
            configDelay = 8'(d);
            tick();
            run = 0;
        end
        for (int i = 0; i <= d; i++) begin
            in0 = $urandom;
            in1 = $urandom;
            configDelay = 8'($urandom);
            if (!done) lows++;
            if (out_valid) stray++;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            in0 = h_init[i];
            in1 = $urandom;
            if (!done) lows++;
            if (out_valid) stray++;
            tick();
        end
        for (int t = 0; t < 64; t++) begin
            in0 = w_tab[t];
            in1 = k_tab[t];
            if (!done) lows++;
            if (out_valid) stray++;
            tick();
            if (t == 0 && r0) begin
                chk("round0_a", dut.w[0], 32'h5d6aebcd);
                chk("round0_e", dut.w[4], 32'hfa2a4622);
            end
        end
        chk("no_stray_valid", 32'(stray), 32'd0);
        for (int i = 0; i < 8; i++) begin
            in0 = $urandom;
            in1 = $urandom;
            chk($sformatf("valid_w%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("digest_w%0d", i), out0, digest[i]);
            if (!done) lows++;
            if (i == rw) begin
                rst = 0;
                tick();
                rst = 1;
                chk("abort_done", 32'(done), 32'd1);
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_out0", out0, 32'd0);
                return;
            end
            if (i == 7 && chain) begin
                run = 1;
                configDelay = 8'(cd);
            end
            tick();
        end
        chk("done_low_cycles", 32'(lows), 32'(d + 1 + 8 + 64 + 8));
        if (chain) begin
            run = 0;
            return;
        end
        chk("end_done", 32'(done), 32'd1);
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_out0", out0, 32'd0);
    endtask
    initial begin
        for (int t = 0; t < 16; t++) w_tab[t] = 32'h0;
        w_tab[0] = 32'h61626380;
        w_tab[15] = 32'h00000018;
        for (int t = 16; t < 64; t++)
            w_tab[t] = (rr(w_tab[t-2], 17) ^ rr(w_tab[t-2], 19) ^ (w_tab[t-2] >> 10)) + w_tab[t-7]
                     + (rr(w_tab[t-15], 7) ^ rr(w_tab[t-15], 18) ^ (w_tab[t-15] >> 3)) + w_tab[t-16];
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            run = 1'($urandom);
            in0 = $urandom;
            in1 = $urandom;
            configDelay = 8'($urandom);
            tick();
        end
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out0", out0, 32'd0);
        rst = 1;
        run = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_done", 32'(done), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        do_block(0, 0, 0, 0, -1, 1);
        do_block(5, 0, 0, 0, -1, 0);
        run = 1;
        configDelay = 0;
        tick();
        run = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            in0 = $urandom;
            tick();
        end
        for (int t = 0; t < 30; t++) begin
            in0 = $urandom;
            in1 = $urandom;
            tick();
        end
        run = 1;
        configDelay = 0;
        tick();
        run = 0;
        do_block(0, 1, 0, 0, -1, 0);
        do_block(0, 0, 0, 0, 3, 0);
        do_block(0, 0, 0, 0, -1, 0);
        do_block(0, 0, 1, 2, -1, 0);
        do_block(2, 1, 0, 0, -1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
